// File: rtl/food_spawner.sv
// Food placement engine for the snake game: random draws against the body
// occupancy memory, a linear-scan fallback, and a sticky full-board flag.
module food_spawner #(
   parameter int GRID_X_BITS = 4,
   parameter int GRID_Y_BITS = 3,
   parameter int MAX_TRIES   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [6:0]             rand_num,
   input  logic                   spawn_req,
   output logic                   busy,
   output logic                   q_valid,
   output logic [6:0]             q_idx,
   input  logic                   q_occ,
   output logic                   food_valid,
   output logic [GRID_X_BITS-1:0] food_x,
   output logic [GRID_Y_BITS-1:0] food_y,
   output logic                   board_full
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RAND  = 2'd1,
      QUERY = 2'd2,
      CHECK = 2'd3
   } state_t;

   localparam logic [6:0] LAST_TRY  = 7'(MAX_TRIES - 1);
   localparam logic [6:0] LAST_SCAN = 7'd127;

   state_t     state_q;
   logic [6:0] cand_q;
   logic [6:0] tries_q;
   logic [6:0] scanned_q;
   logic       scan_mode_q;
   logic [6:0] food_idx_q;
   logic       food_valid_q;
   logic       board_full_q;
   logic       busy_q;

   // Spawn sequencer: draw, query, check, retry or scan, then publish.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cand_q       <= 7'd0;
         tries_q      <= 7'd0;
         scanned_q    <= 7'd0;
         scan_mode_q  <= 1'b0;
         food_idx_q   <= 7'd0;
         food_valid_q <= 1'b0;
         board_full_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         food_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (spawn_req) begin
                  state_q      <= RAND;
                  tries_q      <= 7'd0;
                  scanned_q    <= 7'd0;
                  scan_mode_q  <= 1'b0;
                  board_full_q <= 1'b0;
                  busy_q       <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            RAND: begin
               cand_q  <= rand_num;
               state_q <= QUERY;
            end
            QUERY: begin
               state_q <= CHECK;
            end
            CHECK: begin
               if (!q_occ) begin
                  food_idx_q   <= cand_q;
                  food_valid_q <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= IDLE;
               end else if (!scan_mode_q) begin
                  if (tries_q < LAST_TRY) begin
                     tries_q <= tries_q + 7'd1;
                     state_q <= RAND;
                  end else begin
                     // Random budget spent: walk upward from the last draw.
                     scan_mode_q <= 1'b1;
                     cand_q      <= cand_q + 7'd1;
                     scanned_q   <= 7'd1;
                     state_q     <= QUERY;
                  end
               end else if (scanned_q != LAST_SCAN) begin
                  cand_q    <= cand_q + 7'd1;
                  scanned_q <= scanned_q + 7'd1;
                  state_q   <= QUERY;
               end else begin
                  board_full_q <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Query strobe decoded straight from registered state and candidate.
   assign q_valid    = (state_q == QUERY);
   assign q_idx      = cand_q;

   assign busy       = busy_q;
   assign food_valid = food_valid_q;
   assign board_full = board_full_q;
   assign food_x     = food_idx_q[GRID_X_BITS-1:0];
   assign food_y     = food_idx_q[6:GRID_X_BITS];

endmodule

// File: tb/tb_food_spawner.sv
// Directed self-checking bench for food_spawner with registered occupancy models.
module tb_food_spawner;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] rand_num;
   logic       spawn_req;
   logic       busy, q_valid, q_occ, food_valid, board_full;
   logic [6:0] q_idx;
   logic [3:0] food_x;
   logic [2:0] food_y;
   logic [127:0] occ;

   logic       rand2, spawn2;
   logic [6:0] rand_num2;
   logic       busy2, q_valid2, q_occ2, food_valid2, board_full2;
   logic [6:0] q_idx2;
   logic [3:0] food_x2;
   logic [2:0] food_y2;
   logic [127:0] occ2;

   int checks = 0;
   int errors = 0;
   int qcnt   = 0;
   int fvcnt  = 0;
   int qbase, fvbase;

   always #5 clk = ~clk;

   food_spawner #(.GRID_X_BITS(4), .GRID_Y_BITS(3), .MAX_TRIES(8)) dut (
      .clk(clk), .rst(rst), .rand_num(rand_num), .spawn_req(spawn_req),
      .busy(busy), .q_valid(q_valid), .q_idx(q_idx), .q_occ(q_occ),
      .food_valid(food_valid), .food_x(food_x), .food_y(food_y),
      .board_full(board_full)
   );

   food_spawner #(.GRID_X_BITS(4), .GRID_Y_BITS(3), .MAX_TRIES(2)) dut2 (
      .clk(clk), .rst(rst), .rand_num(rand_num2), .spawn_req(spawn2),
      .busy(busy2), .q_valid(q_valid2), .q_idx(q_idx2), .q_occ(q_occ2),
      .food_valid(food_valid2), .food_x(food_x2), .food_y(food_y2),
      .board_full(board_full2)
   );

   // Registered occupancy memories: result one cycle after the query strobe.
   always @(posedge clk) begin
      if (q_valid) q_occ <= occ[q_idx];
      if (q_valid2) q_occ2 <= occ2[q_idx2];
      if (q_valid) qcnt <= qcnt + 1;
      if (food_valid) fvcnt <= fvcnt + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rand2 = 1'b0;
      q_occ = 1'b0; q_occ2 = 1'b0;
      occ = '0; occ2 = '0;
      rst = 1'b1; spawn_req = 1'b0; rand_num = 7'h00;
      spawn2 = 1'b0; rand_num2 = 7'h00;
      steps(2);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_qvalid", 32'(q_valid), 32'h0);
      check("rst_qidx", 32'(q_idx), 32'h0);
      check("rst_fvalid", 32'(food_valid), 32'h0);
      check("rst_food", 32'({food_y, food_x}), 32'h0);
      check("rst_full", 32'(board_full), 32'h0);
      rst = 1'b0;
      step();

      // Free first draw
      spawn_req = 1'b1;                      // cycle T
      step();                                // T+1
      check("free_busy_rise", 32'(busy), 32'h1);
      spawn_req = 1'b0; rand_num = 7'h35;
      step();                                // T+2
      check("free_qvalid", 32'(q_valid), 32'h1);
      check("free_qidx", 32'(q_idx), 32'h35);
      rand_num = 7'h00;
      step();                                // T+3
      check("free_qvalid_low", 32'(q_valid), 32'h0);
      check("free_fv_early", 32'(food_valid), 32'h0);
      step();                                // T+4
      check("free_fvalid", 32'(food_valid), 32'h1);
      check("free_x", 32'(food_x), 32'h5);
      check("free_y", 32'(food_y), 32'h3);
      check("free_busy_fall", 32'(busy), 32'h0);
      step();
      check("free_fv_pulse", 32'(food_valid), 32'h0);
      check("free_hold", 32'({food_y, food_x}), 32'h35);

      // Retry on collisions
      occ = '0; occ[7'h35] = 1'b1; occ[7'h12] = 1'b1;
      qbase = qcnt;
      spawn_req = 1'b1;                      // T
      step();                                // T+1
      spawn_req = 1'b0; rand_num = 7'h35;
      step();                                // T+2
      check("retry_q1", 32'(q_idx), 32'h35);
      steps(2);                              // T+4 RAND
      check("retry_busy", 32'(busy), 32'h1);
      check("retry_fv_none", 32'(food_valid), 32'h0);
      rand_num = 7'h12;
      step();                                // T+5
      check("retry_q2", 32'(q_idx), 32'h12);
      check("retry_q2_valid", 32'(q_valid), 32'h1);
      steps(2);                              // T+7 RAND
      rand_num = 7'h40;
      step();                                // T+8
      check("retry_q3", 32'(q_idx), 32'h40);
      step();                                // T+9
      check("retry_fv_t9", 32'(food_valid), 32'h0);
      step();                                // T+10
      check("retry_fvalid", 32'(food_valid), 32'h1);
      check("retry_x", 32'(food_x), 32'h0);
      check("retry_y", 32'(food_y), 32'h4);
      check("retry_qcount", 32'(qcnt - qbase), 32'd3);
      step();

      // Scan fallback with wrap (MAX_TRIES=2)
      occ2 = '0; occ2[7'h7F] = 1'b1; occ2[7'h00] = 1'b1;
      rand_num2 = 7'h7F;
      spawn2 = 1'b1;                         // T
      step();
      spawn2 = 1'b0;
      step();                                // T+2
      check("scan_q1", 32'({q_valid2, q_idx2}), 32'hFF);
      steps(3);                              // T+5
      check("scan_q2", 32'({q_valid2, q_idx2}), 32'hFF);
      steps(2);                              // T+7
      check("scan_q3", 32'({q_valid2, q_idx2}), 32'h80);
      steps(2);                              // T+9
      check("scan_q4", 32'({q_valid2, q_idx2}), 32'h81);
      steps(2);                              // T+11
      check("scan_fvalid", 32'(food_valid2), 32'h1);
      check("scan_food", 32'({food_y2, food_x2}), 32'h01);
      check("scan_busy", 32'(busy2), 32'h0);

      // Full board
      occ = '1;
      qbase = qcnt; fvbase = fvcnt;
      rand_num = 7'h10;
      spawn_req = 1'b1;                      // T
      step();
      spawn_req = 1'b0;
      steps(277);                            // T+278
      check("full_busy_t278", 32'(busy), 32'h1);
      steps(2);                              // T+280
      check("full_flag", 32'(board_full), 32'h1);
      check("full_busy", 32'(busy), 32'h0);
      check("full_qcount", 32'(qcnt - qbase), 32'd135);
      check("full_no_fv", 32'(fvcnt - fvbase), 32'd0);
      check("full_food_hold", 32'({food_y, food_x}), 32'h40);
      step();
      check("full_sticky", 32'(board_full), 32'h1);
      occ = '0;
      spawn_req = 1'b1;
      step();
      check("full_clear", 32'(board_full), 32'h0);
      spawn_req = 1'b0;
      steps(3);
      check("full_after_fv", 32'(food_valid), 32'h1);
      check("full_after_food", 32'({food_y, food_x}), 32'h10);
      step();

      // Reset mid-spawn, with a simultaneous request
      fvbase = fvcnt;
      rand_num = 7'h22;
      spawn_req = 1'b1;                      // T
      step();
      spawn_req = 1'b0;
      steps(2);                              // T+3 CHECK
      rst = 1'b1; spawn_req = 1'b1;
      step();                                // T+4
      check("rst_mid_fv", 32'(food_valid), 32'h0);
      check("rst_mid_busy", 32'(busy), 32'h0);
      check("rst_mid_q", 32'({q_valid, q_idx}), 32'h0);
      check("rst_mid_food", 32'({food_y, food_x}), 32'h0);
      rst = 1'b0; spawn_req = 1'b0;
      step();
      check("rst_mid_idle", 32'(busy), 32'h0);
      steps(3);
      check("rst_mid_fvcount", 32'(fvcnt - fvbase), 32'd0);

      // Request while busy
      fvbase = fvcnt;
      spawn_req = 1'b1;                      // T
      step();
      spawn_req = 1'b0; rand_num = 7'h07;
      step();                                // T+2
      spawn_req = 1'b1;
      step();                                // T+3
      spawn_req = 1'b0;
      step();                                // T+4
      check("busy_fvalid", 32'(food_valid), 32'h1);
      check("busy_food", 32'({food_y, food_x}), 32'h07);
      rand_num = 7'h2A;
      spawn_req = 1'b1;
      step();                                // T+5
      check("busy_accept", 32'(busy), 32'h1);
      check("busy_fvcount", 32'(fvcnt - fvbase), 32'd1);
      spawn_req = 1'b0;
      steps(3);
      check("busy_second_fv", 32'(food_valid), 32'h1);
      check("busy_second_food", 32'({food_y, food_x}), 32'h2A);
      step();
      check("busy_one_each", 32'(fvcnt - fvbase), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
